uart_result_tx: RTL and testbench
=================================

# uart_result_tx

Serial transmit stage downstream of the FSM/ALU core. Accepts a 16-bit ALU result through a valid/ready handshake and serializes it on `tx` as two 8N1 UART frames, low byte first, then high byte. Drives the `uart_tx`/`uart_busy` signals the top level routes to `tx` and `uio_out[0]`.

## Interface

Parameters:

- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200). Legal range 2..65535.
- `SEND_HIGH`, default 1: 1 sends both bytes; 0 sends the low byte only.

Ports:

- `clock` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `ena` in 1: global enable. Low freezes the block.
- `data_in` in 16: result word to send.
- `valid` in 1: `data_in` is valid this cycle.
- `ready` out 1: the block can accept a word.
- `tx` out 1: UART serial line, idle high.
- `busy` out 1: a transmission is in progress.

## Operation

- State machine: IDLE → START → DATA → [PARITY] → STOP → (next byte: START | done: IDLE).
- IDLE:
  - `ready`=1, `busy`=0, `tx`=1.
  - On an edge with `valid & ready & ena`: latch `data_in` into a 16-bit shift register, set byte index 0, go to START.
- START: `tx`=0 for one bit time.
- DATA: 8 bits, LSB first, one bit time each. A bit counter 0..7 advances on each baud tick.
- STOP: `tx`=1 for one bit time. Then:
  - if byte index = 0 and `SEND_HIGH`=1: load the high byte, set index 1, go to START with no idle gap.
  - otherwise go to IDLE.
- Baud counter counts 0..`CLKS_PER_BIT`-1. It resets on every state entry and wraps to 0 at the terminal count, producing a one-cycle tick.
- `valid` while `ready`=0 is ignored. The word is not queued, and `data_in` changes during a frame have no effect.
- `ena`=0:
  - baud counter, bit counter and state all hold;
  - `tx` holds its current level;
  - the current bit is stretched by the number of disabled cycles;
  - no acceptance in IDLE.
- `reset` asserted at any time, including mid-frame: the frame is aborted. `tx`=1, `busy`=0, `ready`=1, and all counters are 0, immediately and asynchronously.

## Timing

- Reset values: `tx`=1, `busy`=0, `ready`=1. State IDLE, counters 0, shift register 0.
- All outputs are registered.
- Accept edge N:
  - `ready` falls and `busy` rises after edge N;
  - the start bit is driven from edge N onward, which is the first START cycle.
- Each bit lasts exactly `CLKS_PER_BIT` cycles (with `ena` held high).
- Total busy time: `F`×`B`×`CLKS_PER_BIT` cycles.
  - `F` = 10 bits per frame (11 with parity).
  - `B` = 2 bytes (1 if `SEND_HIGH`=0).
- Completion: on the edge ending the last stop bit, `busy` falls and `ready` rises together. A new word can be accepted on the next edge, giving back-to-back frames with one idle cycle.
- Byte-to-byte: the high-byte start bit immediately follows the low-byte stop bit, with no gap.

## Configuration

- `UART_PARITY_EN` defined:
  - a PARITY state is inserted between DATA and STOP;
  - it sends the even-parity bit (XOR of the 8 data bits);
  - each frame is 11 bits.
- `UART_PARITY_EN` undefined: the PARITY state and its logic are absent, and frames are 8N1 (10 bits).

## Structure

- Shared package `jsilicon_pkg`:
  - `uart_state_t` enum (IDLE, START, DATA, PARITY, STOP);
  - constants `UART_IDLE_LEVEL`=1, `UART_DATA_BITS`=8.
- One sub-module, `uart_baud_gen`:
  - parameterized by `CLKS_PER_BIT`;
  - inputs `clock`, `reset`, `ena`, `restart`;
  - output `tick`.
- The state machine, shift register and byte/bit counters live in `uart_result_tx`.

## Test plan

All scenarios use `CLKS_PER_BIT`=4 and sample `tx` at bit centres.

1. Reset check: assert `reset` for 3 cycles → `tx`=1, `busy`=0, `ready`=1 throughout and after release.
2. Normal send: send 0x12A5 → low frame 0,1,0,1,0,0,1,0,1,1, then high frame 0,0,1,0,0,1,0,0,0,1. `busy`=1 for exactly 80 cycles, then `ready`=1.
3. Ignored `valid`: pulse `valid` with 0xFFFF mid-transmission of 0x12A5 → the line still carries only 0x12A5. After completion, `tx` stays 1 with no further frame.
4. `ena` stall: drop `ena` for 5 cycles during data bit 3 → that bit lasts 9 cycles, the frame is otherwise unchanged, and `busy` lasts 85 cycles.
5. Mid-frame reset: assert `reset` during the high-byte DATA state → `tx`=1 and `busy`=0 in the same cycle. A following send of 0x0055 transmits correctly.
6. Parity and single byte: with `UART_PARITY_EN` and `SEND_HIGH`=1, send 0x0107 → parity bit 1 in both frames, 11-bit frames, `busy`=88 cycles. With `SEND_HIGH`=0 and no macro, send 0x0107 → one frame, `busy`=40 cycles.

Source files
------------

// File: rtl/jsilicon_pkg.sv
// Shared types and constants for the jsilicon UART result transmitter.
package jsilicon_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam logic        UART_IDLE_LEVEL = 1'b1;
  localparam int unsigned UART_DATA_BITS  = 8;

endpackage

// File: rtl/uart_baud_gen.sv
// Baud counter: counts 0..CLKS_PER_BIT-1 and emits a one-cycle tick at the terminal count.
module uart_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic clock,
  input  logic reset,
  input  logic ena,
  input  logic restart,
  output logic tick
);

  localparam logic [15:0] TERM = 16'(CLKS_PER_BIT - 1);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    tick = ena && !restart && (cnt_q == TERM);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (restart)  cnt_d = '0;
    else if (tick) cnt_d = '0;
    else if (ena)  cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_result_tx.sv
// Serializes a 16-bit result as one or two UART frames, low byte first.
// Optional even parity bit per frame when UART_PARITY_EN is defined.
module uart_result_tx
  import jsilicon_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter bit          SEND_HIGH    = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ena,
  input  logic [15:0] data_in,
  input  logic        valid,
  output logic        ready,
  output logic        tx,
  output logic        busy
);

  uart_state_t state_q, state_d;
  logic [15:0] shift_q, shift_d;
  logic        byte_q,  byte_d;
  logic [2:0]  bit_q,   bit_d;
  logic        tx_q,    tx_d;
  logic        busy_q,  busy_d;
  logic        ready_q, ready_d;
  logic        tick;
`ifdef UART_PARITY_EN
  logic        par_q,   par_d;
`endif

  // The counter is held at zero in IDLE, so it starts fresh on acceptance;
  // later state entries coincide with its wrap.
  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clock  (clock),
    .reset  (reset),
    .ena    (ena),
    .restart(state_q == IDLE),
    .tick   (tick)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      byte_q  <= 1'b0;
      bit_q   <= '0;
      tx_q    <= UART_IDLE_LEVEL;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
`ifdef UART_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
`ifdef UART_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    bit_d   = bit_q;
`ifdef UART_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (valid && ready_q && ena) begin
          shift_d = data_in;
          byte_d  = 1'b0;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          bit_d   = '0;
          state_d = DATA;
        end
      end
      // Shifting right through all 16 bits leaves the high byte in [7:0]
      // once the low byte is out, so no separate reload is needed.
      DATA: begin
        if (tick) begin
          shift_d = {1'b0, shift_q[15:1]};
          if (bit_q == 3'(UART_DATA_BITS - 1)) begin
            bit_d = '0;
`ifdef UART_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (tick) state_d = STOP;
      end
`endif
      STOP: begin
        if (tick) begin
          if (!byte_q && SEND_HIGH) begin
            byte_d  = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef UART_PARITY_EN
    if (state_d == START && state_q != START) par_d = ^shift_d[7:0];
`endif
  end

  always_comb begin
    tx_d = UART_IDLE_LEVEL;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = UART_IDLE_LEVEL;
    endcase
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
  end

  assign tx    = tx_q;
  assign busy  = busy_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_uart_result_tx.sv
// Self-checking bench for uart_result_tx: queue-based line model plus literal frame checks.
module tb_uart_result_tx;

  localparam int CPB = 4;
`ifdef UART_PARITY_EN
  localparam int FB  = 11;
  localparam bit PAR = 1'b1;
`else
  localparam int FB  = 10;
  localparam bit PAR = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ena   = 1'b1;
  logic        valid = 1'b0;
  logic [15:0] data_in = '0;
  logic        ready1, tx1, busy1;
  logic        ready2, tx2, busy2;

  int checks = 0;
  int errors = 0;
  int bcnt1 = 0;
  int bcnt2 = 0;

  bit q1[$];
  bit q2[$];

  always #5 clock = ~clock;

  uart_result_tx #(.CLKS_PER_BIT(CPB), .SEND_HIGH(1'b1)) dut1 (
    .clock(clock), .reset(reset), .ena(ena), .data_in(data_in), .valid(valid),
    .ready(ready1), .tx(tx1), .busy(busy1)
  );

  uart_result_tx #(.CLKS_PER_BIT(CPB), .SEND_HIGH(1'b0)) dut2 (
    .clock(clock), .reset(reset), .ena(ena), .data_in(data_in), .valid(valid),
    .ready(ready2), .tx(tx2), .busy(busy2)
  );

  task automatic check(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Line level for bit position i of a frame carrying byte b.
  function automatic bit frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
    if (PAR && i == 9) return ^b;
    return 1'b1;
  endfunction

  // Model: the queue holds the line level for each remaining busy cycle.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      q1.delete();
      q2.delete();
    end else if (ena) begin
      if (q1.size() != 0) void'(q1.pop_front());
      else if (valid)
        for (int b = 0; b < 2; b++)
          for (int i = 0; i < FB; i++)
            for (int c = 0; c < CPB; c++)
              q1.push_back(frame_bit(b == 0 ? data_in[7:0] : data_in[15:8], i));
      if (q2.size() != 0) void'(q2.pop_front());
      else if (valid)
        for (int i = 0; i < FB; i++)
          for (int c = 0; c < CPB; c++)
            q2.push_back(frame_bit(data_in[7:0], i));
    end
  end

  always @(negedge clock) begin
    check("tx1",    tx1,    q1.size() != 0 ? q1[0] : 1'b1);
    check("busy1",  busy1,  q1.size() != 0);
    check("ready1", ready1, q1.size() == 0);
    check("tx2",    tx2,    q2.size() != 0 ? q2[0] : 1'b1);
    check("busy2",  busy2,  q2.size() != 0);
    check("ready2", ready2, q2.size() == 0);
    if (busy1) bcnt1++;
    if (busy2) bcnt2++;
  end

  task automatic wait_idle();
    int n = 0;
    while (!(ready1 && ready2) && n < 2000) begin
      @(posedge clock); #1;
      n++;
    end
    check("wait_idle", ready1 && ready2, 1'b1);
  endtask

  task automatic send(input logic [15:0] w);
    @(negedge clock);
    data_in = w;
    valid   = 1'b1;
    ena     = 1'b1;
    @(posedge clock); #1;
    valid = 1'b0;
  endtask

  // Send and sample both lines at bit centres against literal frames.
  task automatic send_check(input string nm, input logic [15:0] w, input logic [0:21] e);
    int s1, s2;
    wait_idle();
    s1 = bcnt1;
    s2 = bcnt2;
    send(w);
    for (int k = 0; k < 2*FB; k++) begin
      repeat (2) @(posedge clock);
      #1;
      check({nm, "_bit1"}, tx1, e[k]);
      if (k < FB) check({nm, "_bit2"}, tx2, e[k]);
      repeat (2) @(posedge clock);
    end
    #1;
    check({nm, "_done_busy"},  busy1,  1'b0);
    check({nm, "_done_ready"}, ready1, 1'b1);
    @(negedge clock); #1;
    check_int({nm, "_busy1_len"}, bcnt1 - s1, 2*FB*CPB);
    check_int({nm, "_busy2_len"}, bcnt2 - s2, FB*CPB);
  endtask

  logic [0:21] lit_12a5, lit_0107, lit_0055;
  int s1, s2, n, quiet;

  initial begin
`ifdef UART_PARITY_EN
    lit_12a5 = 22'b01010010101_00100100001;
    lit_0107 = 22'b01110000011_01000000011;
    lit_0055 = 22'b01010101001_00000000001;
`else
    lit_12a5 = {20'b0101001011_0010010001, 2'b00};
    lit_0107 = {20'b0111000001_0100000001, 2'b00};
    lit_0055 = {20'b0101010101_0000000001, 2'b00};
`endif

    // Reset held for three cycles
    repeat (3) begin
      @(negedge clock); #1;
      check("rst_tx", tx1, 1'b1);
      check("rst_busy", busy1, 1'b0);
      check("rst_ready", ready1, 1'b1);
    end
    reset = 1'b0;
    @(posedge clock); #1;
    check("post_rst_tx", tx1, 1'b1);
    check("post_rst_ready", ready1, 1'b1);

    send_check("send_12a5", 16'h12A5, lit_12a5);

    // valid pulsed mid-frame must be ignored
    wait_idle();
    s1 = bcnt1;
    send(16'h12A5);
    repeat (10) @(posedge clock);
    #1;
    data_in = 16'hFFFF;
    valid   = 1'b1;
    @(posedge clock); #1;
    valid   = 1'b0;
    wait_idle();
    @(negedge clock); #1;
    check_int("ignored_valid_busy", bcnt1 - s1, 2*FB*CPB);
    quiet = 0;
    repeat (20) begin
      @(negedge clock);
      if (tx1 && !busy1) quiet++;
    end
    check_int("ignored_valid_quiet", quiet, 20);

    // ena dropped for 5 cycles during data bit 3 of the low byte
    wait_idle();
    s1 = bcnt1;
    s2 = bcnt2;
    send(16'h12A5);
    repeat (17) @(posedge clock);
    #1; ena = 1'b0;
    repeat (5) @(posedge clock);
    #1; ena = 1'b1;
    wait_idle();
    @(negedge clock); #1;
    check_int("stall_busy1", bcnt1 - s1, 2*FB*CPB + 5);
    check_int("stall_busy2", bcnt2 - s2, FB*CPB + 5);

    // Asynchronous reset during the high-byte data bits
    wait_idle();
    send(16'h12A5);
    repeat (FB*CPB + 12) @(posedge clock);
    #2; reset = 1'b1;
    #1;
    check("midrst_tx", tx1, 1'b1);
    check("midrst_busy", busy1, 1'b0);
    check("midrst_ready", ready1, 1'b1);
    @(negedge clock);
    reset = 1'b0;
    send_check("send_0055", 16'h0055, lit_0055);

    send_check("send_0107", 16'h0107, lit_0107);

    // Randomized words with random ena gaps and stray valid pulses
    for (int it = 0; it < 25; it++) begin
      wait_idle();
      send(16'($urandom));
      n = 0;
      while ((busy1 || busy2) && n < 1500) begin
        @(posedge clock); #1;
        ena     = ($urandom_range(0, 7) != 0);
        valid   = (n < 150) && ($urandom_range(0, 15) == 0);
        data_in = 16'($urandom);
        n++;
      end
      ena   = 1'b1;
      valid = 1'b0;
      check("rand_done", busy1 || busy2, 1'b0);
    end

    wait_idle();
    repeat (3) @(posedge clock);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

endmodule
